// File: rtl/data_mem_bank.sv
// data_mem_bank: byte-write data store with one read port, selectable read latency and a zeroing sweep.
// Optional macro DATA_MEM_BANK_FWD_EN makes same-address write/read collisions write-first per byte.
module data_mem_bank #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  wea,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [DATA_W-1:0]     dina,
    input  logic [DATA_W/8-1:0]   bea,
    input  logic                  reb,
    input  logic [ADDR_W-1:0]     addrb,
    output logic [DATA_W-1:0]     doutb,
    output logic                  doutb_vld,
    output logic                  wr_drop,
    output logic                  rd_drop
);
    localparam int                NB        = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ZERO_W    = {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                wr_drop_q, rd_drop_q;
    logic                doutb_vld_q;
    logic [DATA_W-1:0]   doutb_q;

    logic                idle_s, wa_ok_s, rb_ok_s, wr_acc_s, rd_acc_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic                out_load_s;
    logic [DATA_W-1:0]   out_data_s;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
            else       res[8*i +: 8] = old_w[8*i +: 8];
        end
        return res;
    endfunction

    assign idle_s   = (state_q == ST_IDLE);
    assign wa_ok_s  = ({1'b0, addra} < DEPTH_W);
    assign rb_ok_s  = ({1'b0, addrb} < DEPTH_W);
    assign wr_acc_s = idle_s && wea && wa_ok_s;
    assign rd_acc_s = idle_s && reb;

    // Read word seen at issue; out-of-range reads return zero.
    always_comb begin
        rd_word_s = ZERO_W;
        if (rb_ok_s) begin
`ifdef DATA_MEM_BANK_FWD_EN
            if (wr_acc_s && (addra == addrb)) rd_word_s = merge_bytes(mem_q[addrb], dina, bea);
            else                              rd_word_s = mem_q[addrb];
`else
            rd_word_s = mem_q[addrb];
`endif
        end else begin
            rd_word_s = ZERO_W;
        end
    end

    // Sweep FSM next state: CLEAR walks every word once, IDLE waits for a clear request.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = {ADDR_W{1'b0}};
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = {ADDR_W{1'b0}};
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // FSM state and drop-strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= {ADDR_W{1'b0}};
            wr_drop_q <= 1'b0;
            rd_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wr_drop_q <= !idle_s && wea;
            rd_drop_q <= !idle_s && reb;
        end
    end

    // Array write: the sweep owns the array while clearing, port A otherwise.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) mem_q[clr_ptr_q] <= ZERO_W;
        else if (wr_acc_s)       mem_q[addra]     <= merge_bytes(mem_q[addra], dina, bea);
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s1_vld_q;
            logic [DATA_W-1:0] s1_data_q;

            // Extra stage; data is captured at issue so later writes cannot disturb it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= ZERO_W;
                end else begin
                    s1_vld_q  <= rd_acc_s;
                    if (rd_acc_s) s1_data_q <= rd_word_s;
                end
            end
            assign out_load_s = s1_vld_q;
            assign out_data_s = s1_data_q;
        end else begin : g_lat1
            assign out_load_s = rd_acc_s;
            assign out_data_s = rd_word_s;
        end
    endgenerate

    // Output stage: doutb holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doutb_q     <= ZERO_W;
            doutb_vld_q <= 1'b0;
        end else begin
            doutb_vld_q <= out_load_s;
            if (out_load_s) doutb_q <= out_data_s;
        end
    end

    assign busy      = (state_q == ST_CLEAR);
    assign doutb     = doutb_q;
    assign doutb_vld = doutb_vld_q;
    assign wr_drop   = wr_drop_q;
    assign rd_drop   = rd_drop_q;

endmodule

// File: tb/tb_data_mem_bank.sv
// Scoreboard bench: instance 0 uses defaults (RD_LAT=1, DEPTH=256), instance 1 uses RD_LAT=2, DEPTH=200.
module tb_data_mem_bank;
    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  rst_n, clr_req, wea, reb;
    logic [1:0]  busy, doutb_vld, wr_drop, rd_drop;
    logic [7:0]  addra [2];
    logic [7:0]  addrb [2];
    logic [7:0]  bea   [2];
    logic [63:0] dina  [2];
    logic [63:0] doutb [2];

    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   cur_run [2];
    int   last_run [2];

    data_mem_bank u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .clr_req(clr_req[0]), .busy(busy[0]),
        .wea(wea[0]), .addra(addra[0]), .dina(dina[0]), .bea(bea[0]),
        .reb(reb[0]), .addrb(addrb[0]), .doutb(doutb[0]), .doutb_vld(doutb_vld[0]),
        .wr_drop(wr_drop[0]), .rd_drop(rd_drop[0])
    );

    data_mem_bank #(.DATA_W(64), .ADDR_W(8), .DEPTH(200), .RD_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .clr_req(clr_req[1]), .busy(busy[1]),
        .wea(wea[1]), .addra(addra[1]), .dina(dina[1]), .bea(bea[1]),
        .reb(reb[1]), .addrb(addrb[1]), .doutb(doutb[1]), .doutb_vld(doutb_vld[1]),
        .wr_drop(wr_drop[1]), .rd_drop(rd_drop[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        wea     = 2'b00;
        reb     = 2'b00;
        clr_req = 2'b00;
    endtask

    task automatic wr(input int d, input logic [7:0] a, input logic [63:0] v, input logic [7:0] be);
        wea[d]   = 1'b1;
        addra[d] = a;
        dina[d]  = v;
        bea[d]   = be;
    endtask

    task automatic rd(input int d, input logic [7:0] a, input logic [63:0] e);
        exp_t x;
        reb[d]   = 1'b1;
        addrb[d] = a;
        x.data   = e;
        x.cyc    = cyc + ((d == 0) ? 1 : 2);
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic wait_idle(input int d, input int exp_len);
        int n;
        n = 0;
        while (busy[d] && n < 600) begin
            tick();
            n++;
        end
        chk("busy_timeout", {63'd0, busy[d]}, 64'd0);
        @(negedge clk);
        #1;
        chk("busy_length", 64'(last_run[d]), 64'(exp_len));
        tick();
    endtask

    // Busy run-length recorder.
    initial begin
        cur_run  = '{0, 0};
        last_run = '{0, 0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n[d])   cur_run[d] = 0;
                else if (busy[d]) cur_run[d] = cur_run[d] + 1;
                else if (cur_run[d] != 0) begin
                    last_run[d] = cur_run[d];
                    cur_run[d]  = 0;
                end
            end
        end
    end

    // Monitor: every vld strobe pops one expected read and checks data and arrival cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n[0] && doutb_vld[0]) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL rd0_unexpected_vld actual=%h cycle=%0d", doutb[0], cyc);
                end else begin
                    x = q0.pop_front();
                    if (doutb[0] !== x.data || cyc != x.cyc) begin
                        failures++;
                        $display("FAIL rd0_data actual=%h@%0d required=%h@%0d", doutb[0], cyc, x.data, x.cyc);
                    end
                end
            end
            if (rst_n[1] && doutb_vld[1]) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL rd1_unexpected_vld actual=%h cycle=%0d", doutb[1], cyc);
                end else begin
                    x = q1.pop_front();
                    if (doutb[1] !== x.data || cyc != x.cyc) begin
                        failures++;
                        $display("FAIL rd1_data actual=%h@%0d required=%h@%0d", doutb[1], cyc, x.data, x.cyc);
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] coll_exp;
        rst_n = 2'b00; clr_req = 2'b00; wea = 2'b00; reb = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addra[d] = 8'd0; addrb[d] = 8'd0; bea[d] = 8'd0; dina[d] = 64'd0;
        end
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_doutb", doutb[d], 64'd0);
            chk("rst_vld_busy_drops", {60'd0, doutb_vld[d], busy[d], wr_drop[d], rd_drop[d]}, 64'h4);
        end

        // Instance 0: power-up sweep then basic reads.
        rst_n[0] = 1'b1;
        wait_idle(0, 256);
        for (int a = 0; a < 5; a++) begin
            rd(0, 8'(a), 64'd0);
            tick();
        end
        wr(0, 8'd1, 64'h1122334455667788, 8'hFF); tick();
        rd(0, 8'd1, 64'h1122334455667788);        tick();
        wr(0, 8'd2, 64'hFFFFFFFFFFFFFFFF, 8'hFF); tick();
        wr(0, 8'd2, 64'h0000000000000000, 8'h0F); tick();
        rd(0, 8'd2, 64'hFFFFFFFF00000000);        tick();

        // Same-address collision.
        wr(0, 8'd3, 64'hAAAAAAAAAAAAAAAA, 8'hFF); tick();
`ifdef DATA_MEM_BANK_FWD_EN
        coll_exp = 64'h55555555AAAAAAAA;
`else
        coll_exp = 64'hAAAAAAAAAAAAAAAA;
`endif
        wr(0, 8'd3, 64'h5555555555555555, 8'hF0);
        rd(0, 8'd3, coll_exp);                    tick();
        rd(0, 8'd3, 64'h55555555AAAAAAAA);        tick();

        // Write right after a read issue must not leak into it; doutb holds afterwards.
        rd(0, 8'd1, 64'h1122334455667788);        tick();
        wr(0, 8'd1, 64'hDEADBEEFCAFEF00D, 8'hFF); tick();
        rd(0, 8'd1, 64'hDEADBEEFCAFEF00D);        tick();
        tick();
        chk("hold_doutb", doutb[0], 64'hDEADBEEFCAFEF00D);
        chk("hold_vld", {63'd0, doutb_vld[0]}, 64'd0);
        wr(0, 8'd1, 64'h0, 8'h00);                tick();
        rd(0, 8'd1, 64'hDEADBEEFCAFEF00D);        tick();

        // Clear request with dropped write/read and an ignored second request.
        clr_req[0] = 1'b1; tick();
        tick(); tick(); tick();
        wr(0, 8'd0, 64'h7777777777777777, 8'hFF);
        reb[0] = 1'b1; addrb[0] = 8'd4; clr_req[0] = 1'b1;
        tick();
        chk("wr_drop_pulse", {63'd0, wr_drop[0]}, 64'd1);
        chk("rd_drop_pulse", {63'd0, rd_drop[0]}, 64'd1);
        tick();
        chk("drops_end", {62'd0, wr_drop[0], rd_drop[0]}, 64'd0);
        wait_idle(0, 256);
        for (int a = 0; a < 4; a++) begin
            rd(0, 8'(a), 64'd0);
            tick();
        end

        // Instance 1: RD_LAT=2, DEPTH=200.
        rst_n[1] = 1'b1;
        wait_idle(1, 200);
        wr(1, 8'd1, 64'h0123456789ABCDEF, 8'hFF);   tick();
        wr(1, 8'd250, 64'hFFFFFFFFFFFFFFFF, 8'hFF); tick();
        rd(1, 8'd0, 64'd0);                 tick();
        rd(1, 8'd1, 64'h0123456789ABCDEF);  tick();
        rd(1, 8'd2, 64'd0);                 tick();
        rd(1, 8'd250, 64'd0);               tick();
        tick(); tick(); tick();

        // Read in flight across a clear returns pre-clear data.
        rd(1, 8'd1, 64'h0123456789ABCDEF);
        clr_req[1] = 1'b1;
        tick();
        wait_idle(1, 200);
        rd(1, 8'd1, 64'd0); tick();
        tick(); tick(); tick();

        // Reset in the middle of a read stream.
        rd(1, 8'd0, 64'd0); tick();
        rd(1, 8'd1, 64'd0); tick();
        rd(1, 8'd2, 64'd0); tick();
        chk("stream_vld_before_rst", {63'd0, doutb_vld[1]}, 64'd1);
        rst_n[1] = 1'b0;
        #1;
        chk("rst_mid_vld", {63'd0, doutb_vld[1]}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy[1]}, 64'd1);
        q1.delete();
        tick();
        rst_n[1] = 1'b1;
        wait_idle(1, 200);

        tick(); tick(); tick(); tick();
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
